// File: rtl/instr_fetch_unit_if.sv
// Fetch-unit bus interface.
// Groups the ROM read port and the issue handshake to the control circuit.
//   romAddr  : PC driven to the program ROM (fetch unit -> ROM)
//   romData  : combinational ROM word at romAddr (ROM -> fetch unit)
//   opcode   : registered opcode issued to the control circuit
//   execute  : one-cycle issue strobe
//   done     : control circuit finished the current instruction
//   busy     : an issued instruction is still waiting for done
// The master modport belongs to the fetch unit.
// The slave modport belongs to the ROM/control side.
interface instr_fetch_unit_if #(
  parameter int ADDR_W = 8
);
  logic [ADDR_W-1:0] romAddr;
  logic [7:0]        romData;
  logic [7:0]        opcode;
  logic              execute;
  logic              done;
  logic              busy;

  modport master (
    output romAddr,
    output opcode,
    output execute,
    output busy,
    input  romData,
    input  done
  );

  modport slave (
    input  romAddr,
    input  opcode,
    input  execute,
    input  busy,
    output romData,
    output done
  );
endinterface

// File: rtl/instr_fetch_unit.sv
// Instruction fetch unit for the 4-bit processor datapath.
// Sequences the PC and fetches opcodes from the program ROM (run mode), or
// takes them from the manual switches on each debounced button press
// (single-step mode). Opcodes are issued one at a time with a one-cycle
// execute strobe, and the unit waits for done before issuing the next one.
// Ports:
//   i_clock               : system clock, all state on rising edge
//   i_reset               : synchronous active-high reset
//   i_singleStep          : 1 = manual opcode per button press, 0 = run from ROM
//   i_buttonForSingleStep : raw asynchronous, bouncy push button
//   i_opCode              : manual opcode switches
//   o_isRomDone           : sticky flag, ROM program completed
//   fetchBus              : ROM port and issue handshake (master side)
module instr_fetch_unit #(
  parameter int ADDR_W          = 8,
  parameter int PROG_LEN        = 16,
  parameter int DEBOUNCE_CYCLES = 4
) (
  input  logic                i_clock,
  input  logic                i_reset,
  input  logic                i_singleStep,
  input  logic                i_buttonForSingleStep,
  input  logic [7:0]          i_opCode,
  output logic                o_isRomDone,
  instr_fetch_unit_if.master  fetchBus
);

  localparam int CNT_W = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
  localparam logic [CNT_W-1:0]  DB_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);
  localparam logic [ADDR_W-1:0] LAST_PC = ADDR_W'(PROG_LEN - 1);

  typedef enum logic [0:0] {
    IDLE      = 1'b0,
    WAIT_DONE = 1'b1
  } state_t;

  logic             r_sync1;
  logic             r_sync2;
  logic             r_dbLevel;
  logic             r_dbLevelPrev;
  logic [CNT_W-1:0] r_dbCount;
  logic             w_pressPulse;

  state_t           r_state;
  logic [ADDR_W-1:0] r_pc;
  logic [7:0]       r_opcode;
  logic             r_execute;
  logic             r_busy;
  logic             r_romDone;
  logic             r_fromRom;

  state_t           w_nextState;
  logic [ADDR_W-1:0] w_nextPc;
  logic [7:0]       w_nextOpcode;
  logic             w_nextExecute;
  logic             w_nextBusy;
  logic             w_nextRomDone;
  logic             w_nextFromRom;

  // The button first passes through a two-flop synchronizer.
  // A stable-level filter follows it. The debounced level flips only after
  // the synchronized input has disagreed with it for DEBOUNCE_CYCLES
  // cycles in a row. Any agreeing cycle restarts the count. r_dbLevelPrev
  // remembers the previous debounced level so that a rising edge can be
  // turned into a single press pulse.
  always_ff @(posedge i_clock) begin
    if (i_reset) begin
      r_sync1       <= 1'b0;
      r_sync2       <= 1'b0;
      r_dbLevel     <= 1'b0;
      r_dbLevelPrev <= 1'b0;
      r_dbCount     <= '0;
    end else begin
      r_sync1       <= i_buttonForSingleStep;
      r_sync2       <= r_sync1;
      r_dbLevelPrev <= r_dbLevel;
      if (r_sync2 == r_dbLevel) begin
        r_dbCount <= '0;
      end else if (r_dbCount == DB_LAST) begin
        r_dbLevel <= ~r_dbLevel;
        r_dbCount <= '0;
      end else begin
        r_dbCount <= r_dbCount + 1'b1;
      end
    end
  end

  // The press pulse lasts one cycle. It fires on a debounced 0->1 edge only.
  assign w_pressPulse = r_dbLevel & ~r_dbLevelPrev;

  // Next-state logic for the issue FSM.
  // Every next value defaults to its current value, except execute, which
  // defaults low so that it can only form a one-cycle pulse.
  // Mode is looked at only in IDLE. The instruction source is latched in
  // r_fromRom at issue time, so a mode change while waiting cannot alter
  // the completion action.
  // The first WAIT_DONE cycle is the execute cycle. Done is ignored there.
  always_comb begin
    w_nextState   = r_state;
    w_nextPc      = r_pc;
    w_nextOpcode  = r_opcode;
    w_nextExecute = 1'b0;
    w_nextBusy    = r_busy;
    w_nextRomDone = r_romDone;
    w_nextFromRom = r_fromRom;
    case (r_state)
      IDLE: begin
        if (!i_singleStep) begin
          if (!r_romDone) begin
            w_nextOpcode  = fetchBus.romData;
            w_nextExecute = 1'b1;
            w_nextBusy    = 1'b1;
            w_nextFromRom = 1'b1;
            w_nextState   = WAIT_DONE;
          end
        end else if (w_pressPulse) begin
          w_nextOpcode  = i_opCode;
          w_nextExecute = 1'b1;
          w_nextBusy    = 1'b1;
          w_nextFromRom = 1'b0;
          w_nextState   = WAIT_DONE;
        end
      end
      WAIT_DONE: begin
        if (!r_execute && fetchBus.done) begin
          w_nextBusy  = 1'b0;
          w_nextState = IDLE;
          if (r_fromRom) begin
            if (r_pc == LAST_PC) begin
              w_nextRomDone = 1'b1;
            end else begin
              w_nextPc = r_pc + 1'b1;
            end
          end
        end
      end
      default: begin
        w_nextState = IDLE;
      end
    endcase
  end

  // State register for the FSM and the datapath registers.
  // Reset has priority over everything, including a done that arrives
  // in the same cycle.
  always_ff @(posedge i_clock) begin
    if (i_reset) begin
      r_state   <= IDLE;
      r_pc      <= '0;
      r_opcode  <= '0;
      r_execute <= 1'b0;
      r_busy    <= 1'b0;
      r_romDone <= 1'b0;
      r_fromRom <= 1'b0;
    end else begin
      r_state   <= w_nextState;
      r_pc      <= w_nextPc;
      r_opcode  <= w_nextOpcode;
      r_execute <= w_nextExecute;
      r_busy    <= w_nextBusy;
      r_romDone <= w_nextRomDone;
      r_fromRom <= w_nextFromRom;
    end
  end

  assign fetchBus.romAddr = r_pc;
  assign fetchBus.opcode  = r_opcode;
  assign fetchBus.execute = r_execute;
  assign fetchBus.busy    = r_busy;
  assign o_isRomDone      = r_romDone;

endmodule
